uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 140 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8-bit UART transmitter with optional parity
// and one or two stop bits; back-to-back frames without idle gap.
module uart_tx_serializer #(
    parameter int CLK_DIV    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       txd,
    output logic       busy
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
    localparam bit PEN  = (PARITY_EN != 0);
    localparam bit PODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    idx, idx_d;
    logic [7:0]    sh, sh_d;
    logic          txd_d, busy_d;
    logic          last, stop_done, accept;

    assign last      = (cnt == CNT_MAX);
    assign stop_done = (state == STOP) && last && (idx == STOP_LAST);
    assign in_ready  = (state == IDLE) || stop_done;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state;
        cnt_d   = last ? '0 : cnt + 1'b1;
        idx_d   = idx;
        sh_d    = sh;
        txd_d   = txd;
        busy_d  = busy;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = START;
                    sh_d    = in_data;
                    idx_d   = '0;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (last) begin
                    state_d = DATA;
                    idx_d   = '0;
                    txd_d   = sh[0];
                end
            end
            DATA: begin
                if (last) begin
                    idx_d = idx + 3'd1;
                    if (idx == 3'd7) begin
                        if (PEN) begin
                            state_d = PARITY;
                            txd_d   = (^sh) ^ PODD;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        txd_d = sh[idx + 3'd1];
                    end
                end
            end
            PARITY: begin
                if (last) begin
                    state_d = STOP;
                    idx_d   = '0;
                    txd_d   = 1'b1;
                end
            end
            STOP: begin
                if (last) begin
                    if (idx == STOP_LAST) begin
                        idx_d = '0;
                        // chain straight into the next start bit
                        if (accept) begin
                            state_d = START;
                            sh_d    = in_data;
                            txd_d   = 1'b0;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                            txd_d   = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        idx_d = idx + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            txd   <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            sh    <= sh_d;
            txd   <= txd_d;
            busy  <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: four parameter sets checked cycle by cycle
// against a frame model built from the UART framing rules.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] valid = '0;
    logic [3:0] txd, busy, rdy;
    logic [7:0] data [4];
    int         nvec = 0;
    int         nerr = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLK_DIV(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(valid[0]), .in_data(data[0]),
        .in_ready(rdy[0]), .txd(txd[0]), .busy(busy[0]));
    uart_tx_serializer #(.CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(valid[1]), .in_data(data[1]),
        .in_ready(rdy[1]), .txd(txd[1]), .busy(busy[1]));
    uart_tx_serializer #(.CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(valid[2]), .in_data(data[2]),
        .in_ready(rdy[2]), .txd(txd[2]), .busy(busy[2]));
    uart_tx_serializer #(.CLK_DIV(3), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(valid[3]), .in_data(data[3]),
        .in_ready(rdy[3]), .txd(txd[3]), .busy(busy[3]));

    function automatic int cdiv(int k);
        return (k == 3) ? 3 : 4;
    endfunction
    function automatic bit pen(int k);
        return (k == 1) || (k == 2);
    endfunction
    function automatic bit podd(int k);
        return k == 2;
    endfunction
    function automatic int nstop(int k);
        return (k == 3) ? 2 : 1;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_chk(int k, int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("u%0d idle txd", k), 32'(txd[k]), 32'd1);
            chk($sformatf("u%0d idle busy", k), 32'(busy[k]), 32'd0);
            chk($sformatf("u%0d idle rdy", k), 32'(rdy[k]), 32'd1);
        end
    endtask

    // n frames (1 or 2, chained); noise drives junk with valid while busy
    task automatic send_seq(int k, int n, logic [7:0] b0, logic [7:0] b1,
                            bit noise);
        logic [7:0] bs [2];
        logic       fb [$];
        int         len;
        bs = '{b0, b1};
        @(negedge clk);
        chk($sformatf("u%0d pre rdy", k), 32'(rdy[k]), 32'd1);
        data[k]  = bs[0];
        valid[k] = 1'b1;
        for (int j = 0; j < n; j++) begin
            fb = {};
            fb.push_back(1'b0);
            for (int i = 0; i < 8; i++) fb.push_back(bs[j][i]);
            if (pen(k)) fb.push_back((^bs[j]) ^ podd(k));
            for (int i = 0; i < nstop(k); i++) fb.push_back(1'b1);
            len = fb.size() * cdiv(k);
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                chk($sformatf("u%0d f%0d c%0d txd", k, j, c),
                    32'(txd[k]), 32'(fb[c / cdiv(k)]));
                chk($sformatf("u%0d f%0d c%0d busy", k, j, c),
                    32'(busy[k]), 32'd1);
                chk($sformatf("u%0d f%0d c%0d rdy", k, j, c),
                    32'(rdy[k]), 32'(c == len - 1));
                if (c == len - 1) begin
                    valid[k] = (j + 1 < n);
                    if (j + 1 < n) data[k] = bs[j + 1];
                end else if (noise) begin
                    valid[k] = 1'b1;
                    data[k]  = 8'($urandom);
                end else begin
                    valid[k] = 1'b0;
                end
            end
        end
        idle_chk(k, 1);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) data[k] = '0;
        #13;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("u%0d rst txd", k), 32'(txd[k]), 32'd1);
            chk($sformatf("u%0d rst busy", k), 32'(busy[k]), 32'd0);
            chk($sformatf("u%0d rst rdy", k), 32'(rdy[k]), 32'd1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_chk(0, 2);

        send_seq(0, 1, 8'h55, 8'h00, 1'b0);
        send_seq(1, 1, 8'h07, 8'h00, 1'b0);
        send_seq(2, 1, 8'h07, 8'h00, 1'b0);
        send_seq(3, 1, 8'h00, 8'h00, 1'b0);
        send_seq(0, 2, 8'hA5, 8'h3C, 1'b0);
        send_seq(0, 1, 8'h12, 8'h00, 1'b1);

        // reset pulse in the middle of data bit 3 of 0xF0
        @(negedge clk);
        data[0]  = 8'hF0;
        valid[0] = 1'b1;
        repeat (18) begin
            @(negedge clk);
            valid[0] = 1'b0;
        end
        chk("u0 pre-rst txd", 32'(txd[0]), 32'd0);
        chk("u0 pre-rst busy", 32'(busy[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("u0 async rst txd", 32'(txd[0]), 32'd1);
        chk("u0 async rst busy", 32'(busy[0]), 32'd0);
        chk("u0 async rst rdy", 32'(rdy[0]), 32'd1);
        #1 rst_n = 1'b1;
        idle_chk(0, 2);
        send_seq(0, 1, 8'h81, 8'h00, 1'b0);

        for (int r = 0; r < 24; r++) begin
            int k;
            k = $urandom_range(0, 3);
            send_seq(k, $urandom_range(1, 2), 8'($urandom), 8'($urandom),
                     1'($urandom_range(0, 1)));
            idle_chk(k, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
